// File: rtl/booth_multiplier_seq_pkg.sv
// Shared types for the sequential Booth multiplier: FSM state encoding and
// the iteration-counter width helper.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARITH  = 3'd1,
        SHIFT  = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_t;

    // The counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Request/response bundle between operand source and the Booth multiplier.
// The master modport drives the operands; the slave modport returns status and the product.
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 4
);
    logic                      start;
    logic signed [WIDTH-1:0]   multiplicand;
    logic signed [WIDTH-1:0]   multiplier;
    logic                      busy;
    logic                      done;
    logic signed [2*WIDTH-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_multiplier_seq_step.sv
// One radix-2 Booth recoding step on the WIDTH+1-bit accumulator:
// subtract, add or pass M depending on the {Q[0], Q-1} pair.
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH:0] a_i,
    input  logic signed [WIDTH:0] m_i,
    input  logic [1:0]            sel_i,
    output logic signed [WIDTH:0] a_o
);
    always_comb begin
        a_o = a_i;
        case (sel_i)
            2'b10:   a_o = a_i - m_i;
            2'b01:   a_o = a_i + m_i;
            default: a_o = a_i;
        endcase
    end
endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// Optional BOOTH_MULTIPLIER_EARLY_EXIT_EN skips trailing no-op iterations via a FINISH state.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_multiplier_seq_if.slave bus
);
    localparam int CW = count_width(WIDTH);

    state_t                    state_q;
    logic signed [WIDTH:0]     a_q;
    logic signed [WIDTH:0]     m_q;
    logic [WIDTH-1:0]          q_q;
    logic                      qm1_q;
    logic [CW-1:0]             count_q;
    logic                      busy_q;
    logic                      done_q;
    logic signed [2*WIDTH-1:0] product_q;

    logic signed [WIDTH:0]     a_step_d;
    logic signed [WIDTH:0]     a_sh_d;
    logic [WIDTH-1:0]          q_sh_d;
    logic                      qm1_sh_d;
    logic [CW-1:0]             count_dec_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i   (a_q),
        .m_i   (m_q),
        .sel_i ({q_q[0], qm1_q}),
        .a_o   (a_step_d)
    );

    // Arithmetic right shift of the {A, Q, Q-1} chain by one position.
    assign a_sh_d      = {a_q[WIDTH], a_q[WIDTH:1]};
    assign q_sh_d      = {a_q[0], q_q[WIDTH-1:1]};
    assign qm1_sh_d    = q_q[0];
    assign count_dec_d = count_q - CW'(1);

`ifdef BOOTH_MULTIPLIER_EARLY_EXIT_EN
    logic [WIDTH:0]              ext_d;
    logic [WIDTH:0]              mask_d;
    logic                        uniform_d;
    logic signed [2*WIDTH+1:0]   full_sh_d;

    // Remaining recoding pairs are all 00 or 11 when the unconsumed low
    // bits of Q (plus Q-1) are uniform; those iterations only shift.
    assign ext_d = {q_sh_d, qm1_sh_d};
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_mask
        assign mask_d[gi] = (gi <= int'(count_dec_d));
    end
    assign uniform_d = (count_dec_d != '0) &&
                       (((ext_d & mask_d) == '0) || ((ext_d & mask_d) == mask_d));
    assign full_sh_d = $signed({a_q, q_q, qm1_q}) >>> count_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= '0;
                        m_q     <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
                        q_q     <= bus.multiplier;
                        qm1_q   <= 1'b0;
                        count_q <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= ARITH;
                    end
                end
                ARITH: begin
                    a_q     <= a_step_d;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    a_q     <= a_sh_d;
                    q_q     <= q_sh_d;
                    qm1_q   <= qm1_sh_d;
                    count_q <= count_dec_d;
                    if (count_dec_d == '0) begin
                        state_q <= DONE;
`ifdef BOOTH_MULTIPLIER_EARLY_EXIT_EN
                    end else if (uniform_d) begin
                        state_q <= FINISH;
`endif
                    end else begin
                        state_q <= ARITH;
                    end
                end
                FINISH: begin
`ifdef BOOTH_MULTIPLIER_EARLY_EXIT_EN
                    {a_q, q_q, qm1_q} <= full_sh_d;
                    count_q           <= '0;
                    state_q           <= DONE;
`else
                    state_q <= IDLE;
`endif
                end
                DONE: begin
                    product_q <= {a_q[WIDTH-1:0], q_q};
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed bench for booth_multiplier_seq at WIDTH=4 and WIDTH=8.
module tb_booth_multiplier_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    booth_multiplier_seq_if #(.WIDTH(4)) bus4 ();
    booth_multiplier_seq_if #(.WIDTH(8)) bus8 ();

    booth_multiplier_seq #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    booth_multiplier_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // Issue one operation on the 4-bit unit; k counts edges after the accept edge (edge 0).
    task automatic op4(input logic signed [3:0] m, input logic signed [3:0] q, input bit interfere,
                       output logic signed [7:0] prod, output int lat, output int dones,
                       output logic [63:0] busy_v);
        lat = -1; dones = 0; busy_v = '0; prod = '0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.multiplicand = m; bus4.multiplier = q;
        @(posedge clk); #1;
        busy_v[0] = bus4.busy;
        bus4.multiplicand = ~m; bus4.multiplier = ~q;
        for (int k = 1; k < 48; k++) begin
            bus4.start = interfere && (k == 3 || k == 5);
            if (bus4.start) begin
                bus4.multiplicand = 4'sd7; bus4.multiplier = -4'sd1;
            end
            @(posedge clk); #1;
            busy_v[k] = bus4.busy;
            if (bus4.done) begin
                dones++;
                if (lat < 0) begin
                    lat = k; prod = bus4.product;
                end
            end
            if (lat >= 0 && k >= lat + 1) break;
        end
        bus4.start = 1'b0;
        $display("op W=4 M=%0d Q=%0d -> product=%0d latency=%0d dones=%0d", m, q, prod, lat, dones);
    endtask

    task automatic op8(input logic signed [7:0] m, input logic signed [7:0] q,
                       output logic signed [15:0] prod, output int lat);
        lat = -1; prod = '0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.multiplicand = m; bus8.multiplier = q;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.multiplicand = ~m; bus8.multiplier = ~q;
        for (int k = 1; k < 64; k++) begin
            @(posedge clk); #1;
            if (bus8.done && lat < 0) begin
                lat = k; prod = bus8.product;
            end
            if (lat >= 0 && k >= lat + 1) break;
        end
        $display("op W=8 M=%0d Q=%0d -> product=%0d latency=%0d", m, q, prod, lat);
    endtask

    task automatic test_reset();
        n_vec++;
        if ({bus4.busy, bus4.done, bus4.product} !== 10'h0) begin
            n_err++; $display("FAIL reset_w4: got %h want 000", {bus4.busy, bus4.done, bus4.product});
        end
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.product} !== 18'h0) begin
            n_err++; $display("FAIL reset_w8: got %h want 00000", {bus8.busy, bus8.done, bus8.product});
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_basic();
        logic signed [7:0] p; int lat, dn; logic [63:0] bv;
        op4(4'sd3, 4'sd2, 1'b0, p, lat, dn, bv);
        n_vec++;
        if (p !== 8'h06) begin n_err++; $display("FAIL basic_product: got %h want 06", p); end
        n_vec++;
        if (dn !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dn); end
`ifndef BOOTH_MULTIPLIER_EARLY_EXIT_EN
        n_vec++;
        if (lat !== 9) begin n_err++; $display("FAIL basic_latency: got %0d want 9", lat); end
        n_vec++;
        if (bv !== 64'h1FF) begin n_err++; $display("FAIL basic_busy: got %h want 1ff", bv); end
`else
        n_vec++;
        if (lat < 0 || lat > 9) begin n_err++; $display("FAIL basic_latency: got %0d want 1..9", lat); end
`endif
    endtask

    task automatic test_corners_w4();
        logic signed [7:0] p; int lat, dn; logic [63:0] bv;
        op4(-4'sd8, -4'sd8, 1'b0, p, lat, dn, bv);
        n_vec++;
        if (p !== 8'h40) begin n_err++; $display("FAIL w4_min_min: got %h want 40", p); end
        op4(-4'sd3, 4'sd5, 1'b0, p, lat, dn, bv);
        n_vec++;
        if (p !== 8'hF1) begin n_err++; $display("FAIL w4_m3_5: got %h want f1", p); end
        op4(4'sd7, -4'sd8, 1'b0, p, lat, dn, bv);
        n_vec++;
        if (p !== 8'hC8) begin n_err++; $display("FAIL w4_7_m8: got %h want c8", p); end
    endtask

    task automatic test_w8();
        logic signed [15:0] p; int lat;
        op8(-8'sd128, -8'sd128, p, lat);
        n_vec++;
        if (p !== 16'h4000) begin n_err++; $display("FAIL w8_min_min: got %h want 4000", p); end
        op8(8'sd127, -8'sd1, p, lat);
        n_vec++;
        if (p !== 16'hFF81) begin n_err++; $display("FAIL w8_127_m1: got %h want ff81", p); end
`ifndef BOOTH_MULTIPLIER_EARLY_EXIT_EN
        n_vec++;
        if (lat !== 17) begin n_err++; $display("FAIL w8_latency: got %0d want 17", lat); end
`endif
    endtask

    task automatic test_start_while_busy();
        logic signed [7:0] p; int lat, dn; logic [63:0] bv;
        op4(4'sd3, -4'sd2, 1'b1, p, lat, dn, bv);
        n_vec++;
        if (p !== 8'hFA) begin n_err++; $display("FAIL busy_ignore_product: got %h want fa", p); end
        n_vec++;
        if (dn !== 1) begin n_err++; $display("FAIL busy_ignore_dones: got %0d want 1", dn); end
    endtask

    task automatic test_abort();
        logic signed [7:0] p; int lat, dn, seen; logic [63:0] bv;
        @(negedge clk);
        bus4.start = 1'b1; bus4.multiplicand = 4'sd5; bus4.multiplier = 4'sd3;
        @(posedge clk); #1; bus4.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({bus4.busy, bus4.done, bus4.product} !== 10'h0) begin
            n_err++; $display("FAIL abort_clear: got %h want 000", {bus4.busy, bus4.done, bus4.product});
        end
        #2 reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus4.done || bus4.busy) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
        op4(-4'sd3, 4'sd5, 1'b0, p, lat, dn, bv);
        n_vec++;
        if (p !== 8'hF1) begin n_err++; $display("FAIL abort_restart: got %h want f1", p); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, b9, b10; logic [7:0] p1, p2;
        d1 = -1; d2 = -1; b9 = -1; b10 = -1; p1 = '0; p2 = '0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.multiplicand = 4'sd3; bus4.multiplier = 4'sd2;
        @(posedge clk); #1;
        bus4.multiplicand = -4'sd3; bus4.multiplier = 4'sd5;
        for (int k = 1; k < 24; k++) begin
            @(posedge clk); #1;
            if (bus4.done) begin
                if (d1 < 0) begin d1 = k; p1 = bus4.product; end
                else if (d2 < 0) begin d2 = k; p2 = bus4.product; bus4.start = 1'b0; end
            end
            if (k == d1)     b9  = int'(bus4.busy);
            if (k == d1 + 1) b10 = int'(bus4.busy);
        end
        bus4.start = 1'b0;
        repeat (24) @(posedge clk);
        $display("b2b done1=%0d p1=%h done2=%0d p2=%h", d1, p1, d2, p2);
        n_vec++;
        if (p1 !== 8'h06) begin n_err++; $display("FAIL b2b_first: got %h want 06", p1); end
        n_vec++;
        if (p2 !== 8'hF1) begin n_err++; $display("FAIL b2b_second: got %h want f1", p2); end
        n_vec++;
        if (b9 !== 0 || b10 !== 1) begin
            n_err++; $display("FAIL b2b_idle_gap: got busy %0d,%0d want 0,1", b9, b10);
        end
`ifndef BOOTH_MULTIPLIER_EARLY_EXIT_EN
        n_vec++;
        if (d1 !== 9 || d2 !== 19) begin
            n_err++; $display("FAIL b2b_timing: got %0d,%0d want 9,19", d1, d2);
        end
`endif
    endtask

`ifdef BOOTH_MULTIPLIER_EARLY_EXIT_EN
    task automatic test_early_exit();
        logic signed [15:0] p; int lat;
        op8(8'sd5, 8'sd0, p, lat);
        n_vec++;
        if (p !== 16'h0000 || lat !== 4) begin
            n_err++; $display("FAIL early_exit_w8: got %h lat %0d want 0000 lat 4", p, lat);
        end
    endtask
`endif

    task automatic test_sweep_w4();
        logic signed [7:0] p; int lat, dn, e; logic [63:0] bv;
        logic signed [3:0] m, q;
        for (int mi = -8; mi < 8; mi++) begin
            for (int qi = -8; qi < 8; qi++) begin
                m = 4'(mi); q = 4'(qi);
                e = mi * qi;
                op4(m, q, 1'b0, p, lat, dn, bv);
                n_vec++;
                if (p !== 8'(e) || lat < 0 || lat > 9) begin
                    n_err++;
                    $display("FAIL sweep M=%0d Q=%0d: got %h lat %0d want %h", mi, qi, p, lat, 8'(e));
                end
            end
        end
    endtask

    initial begin
        bus4.start = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0;
        bus8.start = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_corners_w4();
        test_w8();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
`ifdef BOOTH_MULTIPLIER_EARLY_EXIT_EN
        test_early_exit();
`endif
        test_sweep_w4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier: signed WIDTH x WIDTH operands, signed 2*WIDTH product.
- Next generation of the team's fixed 4-bit Booth datapath: adds a start/busy/done handshake, a correct iteration count for any width, and a WIDTH+1-bit accumulator so the most-negative multiplicand is exact.
- Sits between operand registers and a consumer that samples product on done.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
multiplicand  input  WIDTH  signed M; sampled on the accept edge only
multiplier  input  WIDTH  signed Q; sampled on the accept edge only
busy  output  1  high from the accept edge until the DONE-state edge
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  signed result; held until the next done

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal A, Q, Q-1, M and count cleared.
  - Asserting reset mid-operation aborts the operation; no done is produced.
- Internal registers:
  - A: WIDTH+1 bits, signed.
  - M: WIDTH+1 bits, sign-extended from multiplicand.
  - Q: WIDTH bits.
  - Q-1: 1 bit.
  - count: $clog2(WIDTH+1) bits.
- States and transitions:
  - IDLE: if start=1, load A=0, M=sext(multiplicand), Q=multiplier, Q-1=0, count=WIDTH, busy<=1; go to ARITH. Otherwise stay.
  - ARITH: examine {Q[0],Q-1}.
    - 10: A=A-M.
    - 01: A=A+M.
    - 00 or 11: A unchanged.
    - Go to SHIFT.
  - SHIFT: arithmetic right shift of {A,Q,Q-1} by 1, with A's MSB replicated; count=count-1. If the new count is 0, go to DONE; else go to ARITH.
  - DONE: product<={A[WIDTH-1:0],Q}; done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Arithmetic: add/sub performed at WIDTH+1 bits with no overflow possible. Product is 2*WIDTH bits, which is exact for all input pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Latency: the start-accepting edge is edge 0.
  - The final SHIFT executes at edge 2*WIDTH.
  - done is high after edge 2*WIDTH+1.
  - The next start can be accepted at edge 2*WIDTH+2.
- Boundary conditions:
  - start while busy: ignored. Operands and the running computation are unaffected.
  - start held high continuously: back-to-back operations. One idle cycle (IDLE) separates done and the next load.
  - product and done change only in the DONE state or on reset.

Optional Feature:
- Macro: BOOTH_MULTIPLIER_EARLY_EXIT_EN.
- When defined:
  - In SHIFT, after the shift, if count!=0 and every bit of {Q[count-1:0],Q-1} is equal, go to FINISH instead of ARITH.
  - FINISH: arithmetic right shift of {A,Q,Q-1} by count in one cycle; count=0; go to DONE.
  - Result is identical to the full-iteration result; latency becomes variable and is never greater than without the macro.
- When undefined: no FINISH state; fixed latency as above.

Decomposition:
- Shared package booth_pkg:
  - state enum IDLE/ARITH/SHIFT/FINISH/DONE (FINISH always declared, unused without the macro).
  - localparam function for count width.
- One sub-module, booth_step: combinational add/sub/no-op select for A given {Q[0],Q-1}, WIDTH+1-bit; instantiated once.

Test Plan:
- WIDTH=4, M=3, Q=2, start pulse -> done after edge 9, product=8'h06, busy high edges 0..8.
- WIDTH=4, M=-8, Q=-8 -> product=8'h40 (+64); M=-3, Q=5 -> 8'hF1 (-15); M=7, Q=-8 -> 8'hC8 (-56).
- WIDTH=8, M=-128, Q=-128 -> product=16'h4000; M=127, Q=-1 -> 16'hFF81; done after edge 17.
- WIDTH=4, start re-asserted with new operands at edges 3 and 5 -> ignored; product equals the first operation's result; exactly one done pulse.
- WIDTH=4, reset pulsed at edge 4 -> busy=0, done=0, product=0 asynchronously; no done follows; a fresh start then gives the correct result.
- With BOOTH_MULTIPLIER_EARLY_EXIT_EN, WIDTH=8, M=5, Q=0 -> FINISH after the first SHIFT (edge 2), done after edge 4, product=16'h0000; exhaustive WIDTH=4 sweep matches the macro-off results.
